secded_shift_reg: RTL
=====================

SECDED_SHIFT_REG -- requirements
Module: secded_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width; legal range 4..32.
REQ-002 SHALL have parameter CNT_W, default 8, width of the corrected-error counter.
REQ-003 SHALL derive localparam P as the smallest integer with 2^P >= WIDTH+P+1, and CW = WIDTH+P+1 as the stored codeword width.
REQ-004 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port enable  input  1  enables a shift or load operation this cycle.
REQ-007 SHALL have port mode  input  2  operation select: 00 shift right, 01 shift left, 10 PISO, 11 PIPO.
REQ-008 SHALL have port load  input  1  parallel load qualifier for modes 10 and 11.
REQ-009 SHALL have port serial_in  input  1  serial data input.
REQ-010 SHALL have port parallel_in  input  WIDTH  parallel data input.
REQ-011 SHALL have port inject_mask  input  CW  per-bit fault-injection mask applied to the codeword being written.
REQ-012 SHALL have port clr_err  input  1  clears err_double, err_count and the HALT state.
REQ-013 SHALL have port serial_out  output  1  serial data output.
REQ-014 SHALL have port parallel_out  output  WIDTH  corrected data output.
REQ-015 SHALL have port err_single  output  1  single-bit error present in the stored codeword this cycle.
REQ-016 SHALL have port err_double  output  1  sticky flag for an uncorrectable double-bit error.
REQ-017 SHALL have port err_count  output  CNT_W  saturating count of corrected errors.

Function
REQ-018 SHALL store an extended Hamming codeword with the following layout.
- Bit 0 is the overall parity bit.
- Positions 2^k (k = 0..P-1) hold the Hamming parity bits.
- Data bits occupy the remaining positions 1..CW-1 in ascending order, with data[0] at the lowest such position.
REQ-019 SHALL compute the syndrome combinationally each cycle as the XOR of the indices of all set bits in positions 1..CW-1, together with the overall parity check q = XOR of all CW bits.
REQ-020 SHALL classify the stored codeword as follows.
- Syndrome = 0 and q = 0: clean.
- q = 1: single error at the syndrome position, where syndrome 0 means bit 0.
- Syndrome != 0 and q = 0: double error.
REQ-021 SHALL drive parallel_out combinationally as the corrected data (zero latency), and drive err_single combinationally.
REQ-022 SHALL use corrected data, never raw data, as the source for every shift operation.
REQ-023 SHALL compute the next data exactly as follows.
- Mode 00: {serial_in, d[W-1:1]}.
- Mode 01: {d[W-2:0], serial_in}.
- Mode 10: load ? parallel_in : {0, d[W-1:1]}.
- Mode 11: load ? parallel_in : d.
REQ-024 SHALL drive serial_out as corrected d[0] in modes 00 and 10, and as d[W-1] in modes 01 and 11.
REQ-025 SHALL implement an FSM with states NORMAL, SCRUB and HALT.
REQ-026 In NORMAL with enable=1, SHALL write the encoded next data XOR inject_mask.
REQ-027 In NORMAL with enable=0 and a single error, SHALL go to SCRUB; SCRUB writes the corrected codeword back (inject_mask applied) in one cycle, then returns to NORMAL.
REQ-028 SHALL give enable priority over scrubbing in SCRUB: when enable=1, the operation is performed on corrected data and counts as the scrub.
REQ-029 On detecting a double error in NORMAL or SCRUB, SHALL assert err_double, enter HALT and ignore shifts.
REQ-030 In HALT, SHALL hold parallel_out at the raw data and serial_out at 0.
REQ-031 SHALL exit HALT to NORMAL on any of the following.
- enable=1, load=1 and mode[1]=1: the load is performed.
- clr_err=1.
REQ-032 SHALL increment err_count by 1 on the cycle after every single-error cycle that is written back (scrub or enable), saturating at all-ones.
REQ-033 SHALL give clr_err priority over a simultaneous increment; err_count reads 0 the next cycle.
REQ-034 SHALL apply inject_mask only on cycles where the register is written; the mask is ignored otherwise.

Reset
REQ-035 On rst=0 at a clock edge, SHALL force the codeword to all zeros (a valid encoding of data 0), the FSM to NORMAL, err_double to 0 and err_count to 0.
REQ-036 SHALL give reset priority over enable, inject_mask and clr_err; the reset takes effect mid-operation, including from HALT.

Structure
REQ-037 SHALL place the FSM state enum, the P/CW derivation functions and the data-to-position map function in package secded_pkg.
REQ-038 SHALL implement syndrome and q generation in sub-module secded_syndrome (parameter WIDTH).
REQ-039 SHALL implement encoding as a package function shared by the write path and the testbench model.

Verification (WIDTH=8, P=4, CW=13)
REQ-040 Reset, then load 8'hA5 (mode 11, load=1, enable=1) -> parallel_out=8'hA5 next cycle; err_single=0, err_double=0, err_count=0.
REQ-041 Load 8'hA5 with inject_mask bit 3 set, then enable=0 -> err_single=1 and parallel_out=8'hA5 on the first cycle; one scrub cycle, then err_single=0 and err_count=1.
REQ-042 Load 8'h3C with inject_mask bits 3 and 5 set -> err_double=1 and FSM enters HALT; 4 cycles of mode 00 shifts leave the codeword unchanged; clr_err -> NORMAL, err_double=0.
REQ-043 Mode 00 with serial_in=1 for 8 cycles from 0, with inject of bit 0 on cycle 4 -> parallel_out=8'hFF after 8 cycles, err_count=1.
REQ-044 Force err_count to 255 via repeated single injections, then one more -> err_count stays 255; clr_err together with an injection -> err_count=0.
REQ-045 Assert rst=0 during SCRUB and during HALT -> next cycle codeword=0, FSM=NORMAL, and all flags and the counter at 0.

Source files
------------

// File: rtl/secded_pkg.sv
// Shared types and codeword helpers for the SECDED shift register.
package secded_pkg;

    localparam int unsigned MAX_W  = 32;
    localparam int unsigned MAX_P  = 6;
    localparam int unsigned MAX_CW = MAX_W + MAX_P + 1;
    localparam int unsigned CW_IW  = 6;
    localparam int unsigned D_IW   = 5;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_SCRUB  = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    // Smallest P with 2^P >= width + P + 1
    function automatic int unsigned calc_p(input int unsigned width);
        int unsigned p;
        p = 0;
        for (int unsigned k = 1; k <= MAX_P; k++) begin
            if (p == 0 && (32'd1 << k) >= width + k + 1) p = k;
        end
        return p;
    endfunction

    function automatic int unsigned calc_cw(input int unsigned width);
        return width + calc_p(width) + 1;
    endfunction

    // Codeword position of data bit idx: the idx-th non-power-of-two position >= 1
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned n;
        int unsigned res;
        n   = 0;
        res = 0;
        for (int unsigned p = 1; p < MAX_CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) res = p;
                n++;
            end
        end
        return res;
    endfunction

    // Extended Hamming encode; bits above the real codeword width stay zero
    function automatic logic [MAX_CW-1:0] encode(input logic [MAX_W-1:0] data,
                                                 input int unsigned width);
        logic [MAX_CW-1:0] cw;
        logic              par;
        cw = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < width) cw[CW_IW'(data_pos(i))] = data[D_IW'(i)];
        end
        for (int unsigned k = 0; k < MAX_P; k++) begin
            par = 1'b0;
            for (int unsigned j = 1; j < MAX_CW; j++) begin
                if (((j >> k) & 32'd1) != 0) par = par ^ cw[CW_IW'(j)];
            end
            cw[CW_IW'(32'd1 << k)] = par;
        end
        cw[0] = ^cw[MAX_CW-1:1];
        return cw;
    endfunction

    // Pull the data bits back out of a codeword
    function automatic logic [MAX_W-1:0] extract(input logic [MAX_CW-1:0] cw,
                                                 input int unsigned width);
        logic [MAX_W-1:0] d;
        d = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < width) d[D_IW'(i)] = cw[CW_IW'(data_pos(i))];
        end
        return d;
    endfunction

endpackage

// File: rtl/secded_if.sv
// Control/data bundle between the shift register and its user.
interface secded_if import secded_pkg::*; #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned CNT_W = 8,
    localparam int unsigned CW    = calc_cw(WIDTH)
);
    logic             enable;
    logic [1:0]       mode;
    logic             load;
    logic             serial_in;
    logic [WIDTH-1:0] parallel_in;
    logic [CW-1:0]    inject_mask;
    logic             clr_err;
    logic             serial_out;
    logic [WIDTH-1:0] parallel_out;
    logic             err_single;
    logic             err_double;
    logic [CNT_W-1:0] err_count;

    modport master (
        output enable, mode, load, serial_in, parallel_in, inject_mask, clr_err,
        input  serial_out, parallel_out, err_single, err_double, err_count
    );

    modport slave (
        input  enable, mode, load, serial_in, parallel_in, inject_mask, clr_err,
        output serial_out, parallel_out, err_single, err_double, err_count
    );
endinterface

// File: rtl/secded_syndrome.sv
// Hamming syndrome and overall parity of a stored codeword.
module secded_syndrome import secded_pkg::*; #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned P     = calc_p(WIDTH),
    localparam int unsigned CW    = calc_cw(WIDTH)
) (
    input  logic [CW-1:0] cw,
    output logic [P-1:0]  syndrome,
    output logic          q
);
    localparam int unsigned IW = $clog2(CW);

    // XOR of the indices of all set bits above bit 0, plus full-word parity
    always_comb begin
        syndrome = '0;
        for (int unsigned i = 1; i < CW; i++) begin
            if (cw[IW'(i)]) syndrome = syndrome ^ P'(i);
        end
        q = ^cw;
    end
endmodule

// File: rtl/secded_shift_reg.sv
// Shift register held as an extended Hamming codeword with scrub and halt.
module secded_shift_reg import secded_pkg::*; #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input logic     clk,
    input logic     rst,
    secded_if.slave bus
);
    localparam int unsigned P  = calc_p(WIDTH);
    localparam int unsigned CW = calc_cw(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cw_q;
    logic [CW-1:0]    corr_cw;
    logic [CW-1:0]    enc_next;
    logic [CW-1:0]    wr_cw;
    logic [P-1:0]     syndrome;
    logic             q;
    logic             single_err;
    logic             double_err;
    logic [WIDTH-1:0] raw_d;
    logic [WIDTH-1:0] corr_d;
    logic [WIDTH-1:0] next_d;
    logic             halt_load;
    logic             wr_en;
    logic             cnt_inc;
    logic             set_double;
    logic             err_double_q;
    logic [CNT_W-1:0] err_count_q;

    secded_syndrome #(.WIDTH(WIDTH)) u_syndrome (
        .cw       (cw_q),
        .syndrome (syndrome),
        .q        (q)
    );

    // Classify the stored word and build its corrected form
    always_comb begin
        single_err = q;
        double_err = (syndrome != '0) && !q;
        corr_cw    = single_err ? (cw_q ^ (CW'(1) << syndrome)) : cw_q;
        raw_d      = WIDTH'(extract(MAX_CW'(cw_q), WIDTH));
        corr_d     = WIDTH'(extract(MAX_CW'(corr_cw), WIDTH));
    end

    // Next data word per mode; always derived from corrected data
    always_comb begin
        next_d = corr_d;
        case (bus.mode)
            2'b00:   next_d = {bus.serial_in, corr_d[WIDTH-1:1]};
            2'b01:   next_d = {corr_d[WIDTH-2:0], bus.serial_in};
            2'b10:   next_d = bus.load ? bus.parallel_in : {1'b0, corr_d[WIDTH-1:1]};
            default: next_d = bus.load ? bus.parallel_in : corr_d;
        endcase
    end

    assign enc_next  = CW'(encode(MAX_W'(next_d), WIDTH));
    assign halt_load = bus.enable && bus.load && bus.mode[1];

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_NORMAL;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NORMAL: begin
                if (double_err)                      state_d = ST_HALT;
                else if (!bus.enable && single_err)  state_d = ST_SCRUB;
            end
            ST_SCRUB: state_d = double_err ? ST_HALT : ST_NORMAL;
            ST_HALT:  if (bus.clr_err || halt_load) state_d = ST_NORMAL;
            default:  state_d = ST_NORMAL;
        endcase
    end

    // Per-state write, count and error-flag controls
    always_comb begin
        wr_en      = 1'b0;
        wr_cw      = cw_q;
        cnt_inc    = 1'b0;
        set_double = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                if (double_err) begin
                    set_double = 1'b1;
                end else if (bus.enable) begin
                    wr_en   = 1'b1;
                    wr_cw   = enc_next ^ bus.inject_mask;
                    cnt_inc = single_err;
                end
            end
            ST_SCRUB: begin
                if (double_err) begin
                    set_double = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_cw   = (bus.enable ? enc_next : corr_cw) ^ bus.inject_mask;
                    cnt_inc = single_err;
                end
            end
            ST_HALT: begin
                if (halt_load) begin
                    wr_en = 1'b1;
                    wr_cw = enc_next ^ bus.inject_mask;
                end
            end
            default: ;
        endcase
    end

    // Codeword storage; all-zero is the valid encoding of data 0
    always_ff @(posedge clk) begin
        if (!rst)       cw_q <= '0;
        else if (wr_en) cw_q <= wr_cw;
    end

    // Sticky double-error flag; a fresh detection outranks clr_err
    always_ff @(posedge clk) begin
        if (!rst)             err_double_q <= 1'b0;
        else if (set_double)  err_double_q <= 1'b1;
        else if (bus.clr_err) err_double_q <= 1'b0;
    end

    // Saturating corrected-error counter; clr_err outranks increment
    always_ff @(posedge clk) begin
        if (!rst)                              err_count_q <= '0;
        else if (bus.clr_err)                  err_count_q <= '0;
        else if (cnt_inc && err_count_q != '1) err_count_q <= err_count_q + CNT_W'(1);
    end

    assign bus.parallel_out = (state_q == ST_HALT) ? raw_d : corr_d;
    assign bus.serial_out   = (state_q == ST_HALT) ? 1'b0
                            : (bus.mode[0] ? corr_d[WIDTH-1] : corr_d[0]);
    assign bus.err_single   = single_err;
    assign bus.err_double   = err_double_q;
    assign bus.err_count    = err_count_q;

endmodule
